slow_window_ctl: RTL

- Consumer of the slow-peripheral settings register.
- Watches bus accesses to the legacy I/O devices and asserts Slow when the selected device's Slow* enable bit is set. Slow forces the accelerator into native-speed mode.
- After the access ends, Slow is held for a programmable window of SlowTimeout prescaled ticks, so back-to-back device accesses stay slow.
- Sits between the settings register, the address decoder and the clock/accelerator control logic.

---
 rtl/slow_window_ctl_pkg.sv | 23 ++
 rtl/slow_window_ctl_tick_prescaler.sv | 44 ++++
 rtl/slow_window_ctl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/slow_window_ctl_pkg.sv
// Shared definitions for the slow-peripheral window controller.
//   state_e             : window FSM states
//   Bit*                : bit positions in the slow-peripheral settings register
//   DefaultSlowTimeout  : reset value of the SlowTimeout setting field
package slow_window_ctl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StHold   = 2'd2
  } state_e;

  localparam int unsigned BitIack      = 7;
  localparam int unsigned BitVia       = 6;
  localparam int unsigned BitIwm       = 5;
  localparam int unsigned BitScc       = 4;
  localparam int unsigned BitScsi      = 3;
  localparam int unsigned BitSnd       = 2;
  localparam int unsigned BitClockGate = 1;

  localparam logic [3:0] DefaultSlowTimeout = 4'h3;

endpackage

// File: rtl/slow_window_ctl_tick_prescaler.sv
// Free-running prescaler producing one tick every TICK_DIV enabled cycles.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, count -> 0
//   clear  : synchronous clear to 0 (wins over enable)
//   enable : advance the count this cycle; count holds otherwise
//   tick   : high in the enabled cycle whose count is TICK_DIV-1 (count wraps to 0)
module slow_window_ctl_tick_prescaler #(
  parameter int unsigned TICK_DIV = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned Width = $clog2(TICK_DIV);
  localparam logic [Width-1:0] Last = Width'(TICK_DIV - 1);

  logic [Width-1:0] count_q, count_d;
  logic             at_last;

  assign at_last = (count_q == Last);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = at_last ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = enable & ~clear & at_last;

endmodule

// File: rtl/slow_window_ctl.sv
// Slow-window controller: asserts Slow while an enabled legacy I/O device is
// accessed, then holds it for SlowTimeout prescaled ticks after the access.
//   CLK, nPOR           : clock (rising edge), asynchronous active-low reset
//   BACT                : bus cycle active
//   IACKCS..SndCS       : decoded device selects, valid while BACT is high
//   SlowIACK..SlowSnd   : per-device slow enables from the settings register
//   SlowClockGate       : request clock gating during the window (sampled at ACCESS entry)
//   SlowTimeout[3:0]    : hold length in ticks (sampled at ACCESS->HOLD)
//   Slow                : registered, request native-speed operation
//   ClockGate           : registered, Slow AND the sampled SlowClockGate
//   HoldCount[3:0]      : remaining hold ticks
module slow_window_ctl
  import slow_window_ctl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 256
) (
  input  logic       CLK,
  input  logic       nPOR,
  input  logic       BACT,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic       SlowClockGate,
  input  logic [3:0] SlowTimeout,
  output logic       Slow,
  output logic       ClockGate,
  output logic [3:0] HoldCount
);

  state_e     state_q, state_d;
  logic       bact_r_q;
  logic       armed_q;
  logic       slow_q, slow_d;
  logic       cg_q, cg_d;
  logic [3:0] hold_q, hold_d;

  logic [7:0] sel_vec, en_vec;
  logic       hit, start;
  logic       presc_clear, presc_en, tick;

  // Selects and enables laid out in settings-register bit order.
  always_comb begin
    sel_vec          = '0;
    en_vec           = '0;
    sel_vec[BitIack] = IACKCS;
    sel_vec[BitVia]  = VIACS;
    sel_vec[BitIwm]  = IWMCS;
    sel_vec[BitScc]  = SCCCS;
    sel_vec[BitScsi] = SCSICS;
    sel_vec[BitSnd]  = SndCS;
    en_vec[BitIack]  = SlowIACK;
    en_vec[BitVia]   = SlowVIA;
    en_vec[BitIwm]   = SlowIWM;
    en_vec[BitScc]   = SlowSCC;
    en_vec[BitScsi]  = SlowSCSI;
    en_vec[BitSnd]   = SlowSnd;
  end

  assign hit = |(sel_vec & en_vec);

  // armed_q blocks the first cycle after reset release: a bus cycle already in
  // flight when reset lifts has no rising BACT edge and must not open a window.
  assign start = BACT & ~bact_r_q & armed_q & hit;

  // Prescaler runs only in HOLD; a retrigger freezes it until the next BACT fall.
  assign presc_en    = (state_q == StHold) & ~start;
  assign presc_clear = (state_q == StAccess) & ~BACT;

  slow_window_ctl_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_prescaler (
    .clk   (CLK),
    .rst_n (nPOR),
    .clear (presc_clear),
    .enable(presc_en),
    .tick  (tick)
  );

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      state_q  <= StIdle;
      bact_r_q <= 1'b0;
      armed_q  <= 1'b0;
      slow_q   <= 1'b0;
      cg_q     <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      bact_r_q <= BACT;
      armed_q  <= 1'b1;
      slow_q   <= slow_d;
      cg_q     <= cg_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cg_d    = cg_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAccess;
          cg_d    = SlowClockGate;
        end
      end
      StAccess: begin
        if (!BACT) begin
          if (SlowTimeout != 4'd0) begin
            state_d = StHold;
            hold_d  = SlowTimeout;
          end else begin
            state_d = StIdle;
            hold_d  = '0;
            cg_d    = 1'b0;
          end
        end
      end
      StHold: begin
        if (start) begin
          state_d = StAccess;
          cg_d    = SlowClockGate;
        end else if (tick) begin
          if (hold_q == 4'd1) begin
            state_d = StIdle;
            hold_d  = '0;
            cg_d    = 1'b0;
          end else begin
            hold_d = hold_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        hold_d  = '0;
        cg_d    = 1'b0;
      end
    endcase
    slow_d = (state_d != StIdle);
  end

  always_comb begin
    Slow      = slow_q;
    ClockGate = cg_q;
    HoldCount = hold_q;
  end

endmodule
